// File: rtl/div32.sv
// ============================================================================
//  Module   : div32
//  Purpose  : Sequential restoring shift-subtract unsigned divider. One
//             quotient bit per cycle, MSB first, with divide-by-zero
//             signalling and registered results.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // dvd_q shifts the dividend out at the top while quotient bits enter at the bottom
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] remo_q, remo_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sub;
  logic             ge;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;

  // One restoring step. Because the partial remainder is always below the
  // divisor, a set top trial bit already means trial >= divisor, so the
  // subtractor only needs the low WIDTH bits plus a borrow.
  always_comb begin
    trial    = {rem_q, dvd_q[WIDTH-1]};
    sub      = {1'b0, trial[WIDTH-1:0]} - {1'b0, dsr_q};
    ge       = trial[WIDTH] | ~sub[WIDTH];
    step_rem = ge ? sub[WIDTH-1:0] : trial[WIDTH-1:0];
    step_dvd = {dvd_q[WIDTH-2:0], ge};
  end

  assign accept = start && (state_q != CALC);

  // Next-state and datapath updates; an accept overrides the DONE->IDLE return
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;

    case (state_q)
      CALC: begin
        rem_d = step_rem;
        dvd_d = step_dvd;
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = step_dvd;
          remo_d  = step_rem;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      dvd_d = dividend;
      dsr_d = divisor;
      rem_d = '0;
      cnt_d = CW'(WIDTH - 1);
      dbz_d = 1'b0;
      if (divisor == '0) begin
        state_d = DONE;
        quot_d  = '1;
        remo_d  = dividend;
        dbz_d   = 1'b1;
      end else begin
        state_d = CALC;
      end
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
